// File: rtl/dv_chan_seq.sv
// dv_chan_seq -- stimulus sequencer that feeds a command stream into
// NCH DUT command channels through a single registered output stage.
//
// Flow: IDLE waits for start, RUN accepts commands from the stimulus reader
// and routes each one to the channel named by cmd_chan, DRAIN flushes the
// output stage and waits for every DUT to go idle, DONE holds test_done.
//
// Optional feature: define DV_CHAN_SEQ_WATCHDOG_EN to build an idle watchdog.
// When it is enabled, TIMEOUT cycles in RUN/DRAIN with no accept or drain
// move the sequencer to TOUT, which raises timeout and test_done.
// When it is not defined, timeout is tied low and TOUT is never entered.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               level; begins the run when sampled high in IDLE
//   cmd_*               command from the stimulus reader; cmd_wait is its stall
//   ch_valid            one-hot per channel; ch_addr/ch_data/ch_write shared
//   ch_wait, ch_active  per-channel stall and busy from the DUTs
//   test_done, timeout  sticky completion / watchdog status
//   cmd_count           drained commands (wraps); err_count bad-channel
//                       commands (saturates)
module dv_chan_seq #(
    parameter int NCH     = 4,
    parameter int CHW     = 2,
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TOW     = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           cmd_valid,
    input  logic [CHW-1:0] cmd_chan,
    input  logic [AW-1:0]  cmd_addr,
    input  logic [DW-1:0]  cmd_data,
    input  logic           cmd_write,
    input  logic           cmd_last,
    output logic           cmd_wait,
    output logic [NCH-1:0] ch_valid,
    output logic [AW-1:0]  ch_addr,
    output logic [DW-1:0]  ch_data,
    output logic           ch_write,
    input  logic [NCH-1:0] ch_wait,
    input  logic [NCH-1:0] ch_active,
    output logic           test_done,
    output logic           timeout,
    output logic [15:0]    cmd_count,
    output logic [7:0]     err_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_TOUT  = 3'd4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          write;
    } cmd_t;

    logic [2:0]     state, state_nxt;
    logic [NCH-1:0] vld_q;      // one-hot stage valid; doubles as channel select
    cmd_t           stg_q;
    logic [NCH-1:0] sel_oh;
    logic           occ, stall, drain, accept, chan_ok, wd_fire;

    // One-hot decode of the requested channel; out-of-range selects decode
    // to all zeros and are caught by chan_ok.
    for (genvar i = 0; i < NCH; i++) begin : g_sel
        assign sel_oh[i] = (32'(cmd_chan) == i);
    end

    // Widened compare so the check stays meaningful when NCH == 2**CHW.
    assign chan_ok = (32'(cmd_chan) < NCH);

    // Stage is one-hot, so masking with ch_wait picks the selected channel.
    assign occ      = |vld_q;
    assign stall    = |(vld_q & ch_wait);
    assign drain    = |(vld_q & ~ch_wait);
    assign cmd_wait = (state != S_RUN) | stall;
    assign accept   = cmd_valid & ~cmd_wait;

    assign ch_valid  = vld_q;
    assign ch_addr   = stg_q.addr;
    assign ch_data   = stg_q.data;
    assign ch_write  = stg_q.write;
    assign test_done = (state == S_DONE) | (state == S_TOUT);

`ifdef DV_CHAN_SEQ_WATCHDOG_EN
    logic [TOW-1:0] wd_cnt;
    logic           wd_live;

    assign wd_live = (state == S_RUN) | (state == S_DRAIN);
    // Fires on the cycle that would take the idle count to TIMEOUT; any
    // accept or drain in that same cycle counts as activity and wins.
    assign wd_fire = wd_live & ~(accept | drain) & (wd_cnt == TOW'(TIMEOUT - 1));
    assign timeout = (state == S_TOUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wd_cnt <= '0;
        else if (!wd_live || accept || drain)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + TOW'(1);
    end
`else
    logic [TOW-1:0] unused_wd;
    assign unused_wd = TOW'(TIMEOUT);
    assign wd_fire   = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (wd_fire)                 state_nxt = S_TOUT;
                else if (accept && cmd_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (wd_fire)                    state_nxt = S_TOUT;
                else if (!occ && !(|ch_active)) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_DONE;
            S_TOUT:  state_nxt = S_TOUT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Output stage: refill has priority over drain so back-to-back commands
    // stream at one per cycle. Bad-channel commands are swallowed here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            stg_q <= '0;
        end else if (wd_fire) begin
            vld_q <= '0;
        end else if (accept && chan_ok) begin
            vld_q <= sel_oh;
            stg_q <= '{addr: cmd_addr, data: cmd_data, write: cmd_write};
        end else if (drain) begin
            vld_q <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_count <= '0;
            err_count <= '0;
        end else begin
            cmd_count <= cmd_count + 16'(drain);
            if (accept && !chan_ok && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_dv_chan_seq.sv
// Directed bench for dv_chan_seq (NCH=4, CHW=3 so out-of-range channels can
// be driven, TIMEOUT=20). Inputs change and outputs are checked 1ns after
// the rising edge.
module tb_dv_chan_seq;
    localparam int NCH = 4, CHW = 3, AW = 16, DW = 32, TOW = 16, TIMEOUT = 20;

    logic           clk = 1'b0;
    logic           reset, start, cmd_valid, cmd_write, cmd_last, cmd_wait;
    logic [CHW-1:0] cmd_chan;
    logic [AW-1:0]  cmd_addr, ch_addr;
    logic [DW-1:0]  cmd_data, ch_data;
    logic [NCH-1:0] ch_valid, ch_wait, ch_active;
    logic           ch_write, test_done, timeout;
    logic [15:0]    cmd_count;
    logic [7:0]     err_count;

    int compared = 0;
    int mism     = 0;

    always #5 clk = ~clk;

    dv_chan_seq #(.NCH(NCH), .CHW(CHW), .AW(AW), .DW(DW), .TOW(TOW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cmd_valid(cmd_valid), .cmd_chan(cmd_chan), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_write(cmd_write), .cmd_last(cmd_last),
        .cmd_wait(cmd_wait), .ch_valid(ch_valid), .ch_addr(ch_addr),
        .ch_data(ch_data), .ch_write(ch_write), .ch_wait(ch_wait),
        .ch_active(ch_active), .test_done(test_done), .timeout(timeout),
        .cmd_count(cmd_count), .err_count(err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [CHW-1:0] ch, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic w, input logic l);
        cmd_valid = 1'b1;
        cmd_chan  = ch;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_write = w;
        cmd_last  = l;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cmd_valid = 1'b0; cmd_chan = '0;
        cmd_addr = '0; cmd_data = '0; cmd_write = 1'b0; cmd_last = 1'b0;
        ch_wait = '0; ch_active = '0;
        tick(); tick();

        // Reset state
        chk("rst_ch_valid", 64'(ch_valid), 64'h0);
        chk("rst_cmd_wait", 64'(cmd_wait), 64'h1);
        chk("rst_test_done", 64'(test_done), 64'h0);
        chk("rst_timeout", 64'(timeout), 64'h0);
        chk("rst_cmd_count", 64'(cmd_count), 64'h0);
        chk("rst_err_count", 64'(err_count), 64'h0);

        // Back-to-back commands to channels 0,1,2, last on the third
        reset = 1'b0;
        tick();
        chk("idle_cmd_wait", 64'(cmd_wait), 64'h1);
        start = 1'b1;
        tick();
        chk("run_cmd_wait", 64'(cmd_wait), 64'h0);
        start = 1'b0;                        // no effect once running
        cmd(3'd0, 16'h0010, 32'hA0A0_0000, 1'b1, 1'b0);
        tick();
        chk("a_ch_valid0", 64'(ch_valid), 64'b0001);
        chk("a_ch_addr0", 64'(ch_addr), 64'h0010);
        chk("a_ch_data0", 64'(ch_data), 64'hA0A0_0000);
        chk("a_ch_write0", 64'(ch_write), 64'h1);
        cmd(3'd1, 16'h0011, 32'hA1A1_1111, 1'b0, 1'b0);
        tick();
        chk("a_ch_valid1", 64'(ch_valid), 64'b0010);
        chk("a_ch_write1", 64'(ch_write), 64'h0);
        chk("a_count1", 64'(cmd_count), 64'd1);
        cmd(3'd2, 16'h0012, 32'hA2A2_2222, 1'b1, 1'b1);
        tick();
        chk("a_ch_valid2", 64'(ch_valid), 64'b0100);
        chk("a_count2", 64'(cmd_count), 64'd2);
        cmd_valid = 1'b0;
        #1;
        chk("a_drain_cmd_wait", 64'(cmd_wait), 64'h1);
        tick();
        chk("a_empty_ch_valid", 64'(ch_valid), 64'h0);
        chk("a_count3", 64'(cmd_count), 64'd3);
        chk("a_not_done_yet", 64'(test_done), 64'h0);
        tick();
        chk("a_test_done", 64'(test_done), 64'h1);
        cmd(3'd0, 16'h0099, 32'h0, 1'b0, 1'b0);   // ignored after DONE
        tick(); tick(); tick();
        chk("a_done_sticky", 64'(test_done), 64'h1);
        chk("a_done_ch_valid", 64'(ch_valid), 64'h0);
        chk("a_done_count", 64'(cmd_count), 64'd3);
        chk("a_done_cmd_wait", 64'(cmd_wait), 64'h1);
        cmd_valid = 1'b0;

        // Stall on channel 1 for 5 cycles, then refill, bad channel, drain wait
        reset = 1'b1;
        tick();
        reset = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        cmd(3'd1, 16'h0021, 32'hB1B1_0021, 1'b1, 1'b0);
        ch_wait = 4'b0010;
        tick();
        cmd(3'd3, 16'h0033, 32'hB3B3_0033, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) tick();
            chk($sformatf("b_stall_valid%0d", i), 64'(ch_valid), 64'b0010);
            chk($sformatf("b_stall_addr%0d", i), 64'(ch_addr), 64'h0021);
            chk($sformatf("b_stall_data%0d", i), 64'(ch_data), 64'hB1B1_0021);
            chk($sformatf("b_stall_wait%0d", i), 64'(cmd_wait), 64'h1);
        end
        chk("b_stall_count", 64'(cmd_count), 64'd0);
        ch_wait = 4'b0000;
        #1;
        chk("b_release_cmd_wait", 64'(cmd_wait), 64'h0);
        tick();
        chk("b_refill_valid", 64'(ch_valid), 64'b1000);
        chk("b_refill_addr", 64'(ch_addr), 64'h0033);
        chk("b_refill_count", 64'(cmd_count), 64'd1);
        cmd(3'd5, 16'h0055, 32'h5555_5555, 1'b0, 1'b0);
        tick();
        chk("b_bad_valid", 64'(ch_valid), 64'h0);
        chk("b_bad_err", 64'(err_count), 64'd1);
        chk("b_bad_count", 64'(cmd_count), 64'd2);
        cmd(3'd0, 16'h0040, 32'hB0B0_0040, 1'b1, 1'b1);
        ch_active = 4'b1000;
        tick();
        chk("b_next_valid", 64'(ch_valid), 64'b0001);
        chk("b_next_addr", 64'(ch_addr), 64'h0040);
        cmd_valid = 1'b0;
        tick();
        chk("b_last_drained", 64'(cmd_count), 64'd3);
        repeat (8) tick();
        chk("b_active_hold", 64'(test_done), 64'h0);
        ch_active = 4'b0000;
        #1;
        chk("b_active_fall", 64'(test_done), 64'h0);
        tick();
        chk("b_test_done", 64'(test_done), 64'h1);

        // err_count saturation, then reset while stalled on channel 2
        reset = 1'b1;
        tick();
        reset = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        cmd(3'd7, 16'h0077, 32'h0, 1'b0, 1'b0);
        repeat (255) tick();
        chk("c_err_255", 64'(err_count), 64'd255);
        chk("c_err_no_valid", 64'(ch_valid), 64'h0);
        tick();
        chk("c_err_sat", 64'(err_count), 64'd255);
        cmd(3'd0, 16'h0060, 32'hC0C0_0060, 1'b0, 1'b0);
        tick();
        chk("c_ch0_valid", 64'(ch_valid), 64'b0001);
        cmd(3'd2, 16'h0062, 32'hC2C2_0062, 1'b1, 1'b0);
        ch_wait = 4'b0100;
        tick();
        cmd_valid = 1'b0;
        chk("c_ch2_valid", 64'(ch_valid), 64'b0100);
        chk("c_count1", 64'(cmd_count), 64'd1);
        tick();
        chk("c_ch2_held", 64'(ch_valid), 64'b0100);
        reset = 1'b1;
        #1;
        chk("c_rst_valid", 64'(ch_valid), 64'h0);
        chk("c_rst_addr", 64'(ch_addr), 64'h0);
        chk("c_rst_data", 64'(ch_data), 64'h0);
        chk("c_rst_write", 64'(ch_write), 64'h0);
        chk("c_rst_count", 64'(cmd_count), 64'h0);
        chk("c_rst_err", 64'(err_count), 64'h0);
        chk("c_rst_cmd_wait", 64'(cmd_wait), 64'h1);
        chk("c_rst_done", 64'(test_done), 64'h0);
        tick();
        reset = 1'b0; ch_wait = 4'b0000;
        tick();
        chk("c_post_count", 64'(cmd_count), 64'h0);
        chk("c_post_valid", 64'(ch_valid), 64'h0);
        chk("c_post_idle", 64'(cmd_wait), 64'h1);

        // Idle run with no commands: watchdog behaviour
        start = 1'b1;
        tick();                              // RUN entered at this edge
        start = 1'b0;
        repeat (19) tick();
        chk("d_no_timeout_19", 64'(timeout), 64'h0);
`ifdef DV_CHAN_SEQ_WATCHDOG_EN
        tick();
        chk("d_timeout_20", 64'(timeout), 64'h1);
        chk("d_tout_done", 64'(test_done), 64'h1);
        chk("d_tout_valid", 64'(ch_valid), 64'h0);
        chk("d_tout_cmd_wait", 64'(cmd_wait), 64'h1);
        tick(); tick();
        chk("d_tout_sticky", 64'(timeout), 64'h1);
`else
        repeat (6) tick();
        chk("d_no_timeout", 64'(timeout), 64'h0);
        chk("d_still_running", 64'(test_done), 64'h0);
        chk("d_run_cmd_wait", 64'(cmd_wait), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
